// File: rtl/angle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : angle_pkg
//  Description : Shared types and constants for the potentiometer angle
//                scaler. FSM state encoding, channel-index width helper,
//                and the default scale/limit for a 12-bit ADC front end.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package angle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CENTER = 2'd1,
    ST_MULT   = 2'd2,
    ST_SAT    = 2'd3
  } state_e;

  // A single channel still needs a 1-bit select so the port never collapses
  // to zero width.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // 11/128 deg per LSB: a 12-bit pot spanning roughly +/-176 deg.
  localparam logic [3:0]  SCALE_12B = 4'd11;
  // +180.0 deg in Q9.7.
  localparam logic [15:0] LIMIT_12B = 16'h5A00;

endpackage
`default_nettype wire

// File: rtl/angle_shift_mult.sv
`default_nettype none
// ============================================================================
//  Module      : angle_shift_mult
//  Description : Iterative signed-by-unsigned shift-add multiplier, one
//                multiplier bit per cycle, LSB first.
//  Ports       : clk_i, nReset_i      clock, async active-low reset
//                start_i, a_i, b_i    load operands (signed a, unsigned b)
//                done_o               one-cycle pulse, product_o final
//                product_o            signed A_W+B_W bit product
//  Revision    : 1.0 - initial release
// ============================================================================
module angle_shift_mult #(
  parameter int A_W = 14,
  parameter int B_W = 4
) (
  input  logic                     clk_i,
  input  logic                     nReset_i,
  input  logic                     start_i,
  input  logic signed [A_W-1:0]    a_i,
  input  logic        [B_W-1:0]    b_i,
  output logic                     done_o,
  output logic signed [A_W+B_W-1:0] product_o
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);

  logic signed [P_W-1:0] acc_q;
  logic signed [P_W-1:0] mcand_q;
  logic        [B_W-1:0] mplier_q;
  logic        [CNT_W-1:0] cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic signed [P_W-1:0] a_ext_d;

  assign a_ext_d = P_W'(a_i);

  // The load edge already performs iteration 0, so B_W iterations finish
  // B_W-1 edges after the load and the caller sees done_o one cycle later.
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q    <= b_i[0] ? a_ext_d : '0;
        mcand_q  <= a_ext_d <<< 1;
        mplier_q <= b_i >> 1;
        cnt_q    <= CNT_W'(1);
        busy_q   <= (B_W > 1);
        done_q   <= (B_W == 1);
      end else if (busy_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q <<< 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(B_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/adc_angle_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : adc_angle_scaler
//  Description : Converts unsigned ADC codes from CHANNELS potentiometers
//                into signed fixed-point shaft angles with a per-channel
//                zero offset and symmetric saturation at +/-LIMIT.
//  Ports       : clk_i, nReset_i            clock, async active-low reset
//                start_i, ch_i, adc_i       conversion request
//                zero_wr_i, zero_ch_i, zero_i  zero-offset write port
//                busy_o                     conversion in progress
//                valid_o, ch_o, angle_o, sat_o  registered result
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module adc_angle_scaler
  import angle_pkg::*;
#(
  parameter int ADC_BITS   = 12,
  parameter int WIDTH      = 16,
  parameter int FBITS      = 7,
  parameter int CHANNELS   = 2,
  parameter int SCALE_BITS = 4,
  parameter logic [SCALE_BITS-1:0] SCALE = SCALE_BITS'(SCALE_12B),
  parameter logic [WIDTH-1:0]      LIMIT = WIDTH'(LIMIT_12B)
) (
  input  logic                              clk_i,
  input  logic                              nReset_i,
  input  logic                              start_i,
  input  logic [ch_width(CHANNELS)-1:0]     ch_i,
  input  logic [ADC_BITS-1:0]               adc_i,
  input  logic                              zero_wr_i,
  input  logic [ch_width(CHANNELS)-1:0]     zero_ch_i,
  input  logic [ADC_BITS-1:0]               zero_i,
  output logic                              busy_o,
  output logic                              valid_o,
  output logic [ch_width(CHANNELS)-1:0]     ch_o,
  output logic [WIDTH-1:0]                  angle_o,
  output logic                              sat_o
);

  localparam int CH_W = ch_width(CHANNELS);
  localparam int DW   = ADC_BITS + 2;
  localparam int PW   = DW + SCALE_BITS;
  localparam int EW   = (PW > WIDTH) ? PW : WIDTH;
  localparam logic [DW-1:0]   MID    = DW'(1) << (ADC_BITS - 1);
  localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(CHANNELS);

  // A non-negative limit below full scale keeps the clamped value
  // representable after truncation to WIDTH.
  if (FBITS >= WIDTH || LIMIT[WIDTH-1]) begin : g_bad_params
    $error("adc_angle_scaler: FBITS must be < WIDTH and LIMIT < 2**(WIDTH-1)");
  end

  state_e                state_q;
  logic [ADC_BITS-1:0]   zero_q [CHANNELS];
  logic [ADC_BITS-1:0]   adc_q;
  logic [ADC_BITS-1:0]   zero_cap_q;
  logic [CH_W-1:0]       ch_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [CH_W-1:0]       ch_out_q;
  logic [WIDTH-1:0]      angle_q;
  logic                  sat_q;

  logic [ADC_BITS-1:0]   zero_sel_d;
  logic signed [DW-1:0]  diff_d;
  logic signed [PW-1:0]  product;
  logic                  mult_done;
  logic signed [EW-1:0]  prod_ext_d;
  logic signed [EW-1:0]  lim_pos_d;
  logic signed [EW-1:0]  clamp_d;
  logic                  sat_d;

  // Out-of-range channels convert with a zero offset of 0.
  always_comb begin
    zero_sel_d = '0;
    if ({1'b0, ch_i} < CH_LIM) begin
      zero_sel_d = zero_q[ch_i];
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        zero_q[i] <= '0;
      end
    end else if (zero_wr_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (zero_ch_i == CH_W'(i)) begin
          zero_q[i] <= zero_i;
        end
      end
    end
  end

  // Range is +/-(2^ADC_BITS - 1), so two guard bits make overflow impossible.
  assign diff_d = $signed({2'b00, adc_q}) - $signed(MID)
                - $signed({{2{zero_cap_q[ADC_BITS-1]}}, zero_cap_q});

  angle_shift_mult #(
    .A_W (DW),
    .B_W (SCALE_BITS)
  ) u_mult (
    .clk_i     (clk_i),
    .nReset_i  (nReset_i),
    .start_i   (state_q == ST_CENTER),
    .a_i       (diff_d),
    .b_i       (SCALE),
    .done_o    (mult_done),
    .product_o (product)
  );

  assign prod_ext_d = EW'(product);
  assign lim_pos_d  = EW'(LIMIT);

  always_comb begin
    clamp_d = prod_ext_d;
    sat_d   = 1'b0;
    if (prod_ext_d > lim_pos_d) begin
      clamp_d = lim_pos_d;
      sat_d   = 1'b1;
    end else if (prod_ext_d < -lim_pos_d) begin
      clamp_d = -lim_pos_d;
      sat_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state_q    <= ST_IDLE;
      adc_q      <= '0;
      zero_cap_q <= '0;
      ch_q       <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ch_out_q   <= '0;
      angle_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            adc_q      <= adc_i;
            ch_q       <= ch_i;
            zero_cap_q <= zero_sel_d;
            busy_q     <= 1'b1;
            state_q    <= ST_CENTER;
          end
        end
        ST_CENTER: state_q <= ST_MULT;
        ST_MULT: begin
          if (mult_done) begin
            state_q <= ST_SAT;
          end
        end
        ST_SAT: begin
          angle_q  <= clamp_d[WIDTH-1:0];
          sat_q    <= sat_d;
          ch_out_q <= ch_q;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign ch_o    = ch_out_q;
  assign angle_o = angle_q;
  assign sat_o   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_angle_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_angle_scaler
//  Description : Scoreboard bench for adc_angle_scaler at default parameters.
//                Expected results come from an integer model of the
//                conversion and are queued at request time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_angle_scaler;

  typedef struct {
    logic        ch;
    logic [15:0] angle;
    logic        sat;
    int          edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        ch;
  logic [11:0] adc;
  logic        zwr;
  logic        zch;
  logic [11:0] zval;
  logic        busy_o;
  logic        valid_o;
  logic        ch_o;
  logic [15:0] angle_o;
  logic        sat_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_cnt = 0;
  int   zero_m [2];
  logic [15:0] last_angle = '0;
  exp_t sb [$];

  always #5 clk = ~clk;

  adc_angle_scaler dut (
    .clk_i     (clk),
    .nReset_i  (nrst),
    .start_i   (start),
    .ch_i      (ch),
    .adc_i     (adc),
    .zero_wr_i (zwr),
    .zero_ch_i (zch),
    .zero_i    (zval),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .ch_o      (ch_o),
    .angle_o   (angle_o),
    .sat_o     (sat_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected result: (adc - 2048 - zero) * 11, clamped to +/-23040.
  // The request counts as edge 1, so valid shows after its 7th edge.
  task automatic push_exp(input int c, input int a, input int accept_edge);
    exp_t e;
    int   z;
    int   p;
    z = zero_m[c];
    p = (a - 2048 - z) * 11;
    e.sat = 1'b0;
    if (p > 23040) begin
      p = 23040;
      e.sat = 1'b1;
    end else if (p < -23040) begin
      p = -23040;
      e.sat = 1'b1;
    end
    e.angle  = p[15:0];
    e.ch     = c[0];
    e.edge_n = accept_edge + 6;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", valid_o, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ch_o", ch_o, e.ch);
        check("angle_o", angle_o, e.angle);
        check("sat_o", sat_o, e.sat);
        check("latency_edge", edge_cnt, e.edge_n);
        last_angle = e.angle;
      end
    end
  end

  task automatic convert(input int c, input int a);
    @(negedge clk);
    start = 1'b1;
    ch    = c[0];
    adc   = a[11:0];
    push_exp(c, a, edge_cnt + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic write_zero(input int c, input int z);
    @(negedge clk);
    zwr  = 1'b1;
    zch  = c[0];
    zval = z[11:0];
    @(negedge clk);
    zwr  = 1'b0;
    zero_m[c] = z;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("hold_angle", angle_o, last_angle);
    check("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; ch = 1'b0; adc = '0;
    zwr = 1'b0; zch = 1'b0; zval = '0;
    zero_m[0] = 0; zero_m[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_angle", angle_o, 16'h0000);
    check("rst_sat", sat_o, 1'b0);
    check("rst_ch", ch_o, 1'b0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic conversions with zero offsets at 0.
    convert(0, 12'h800); drain();
    convert(0, 12'hFFF); drain();
    convert(1, 12'h000); drain();

    // Offsets and saturation in both directions.
    write_zero(1, 100);  convert(1, 12'h800); drain();
    write_zero(0, -512); convert(0, 12'hFFF); drain();
    write_zero(1, 1000); convert(1, 12'h000); drain();

    // start held high: accepts every 7 cycles, including in the valid cycle.
    begin
      int e0;
      @(negedge clk);
      start = 1'b1; ch = 1'b0; adc = 12'h123;
      e0 = edge_cnt + 1;
      push_exp(0, 12'h123, e0);
      @(negedge clk);
      ch = 1'b1; adc = 12'hABC;
      push_exp(1, 12'hABC, e0 + 7);
      repeat (7) @(negedge clk);
      ch = 1'b0; adc = 12'hC00;
      push_exp(0, 12'hC00, e0 + 14);
      repeat (7) @(negedge clk);
      start = 1'b0;
      drain();
    end

    // start pulses while busy are dropped.
    convert(0, 12'h850);
    repeat (2) @(negedge clk);
    start = 1'b1; ch = 1'b1; adc = 12'h000;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; adc = 12'hFFF;
    @(negedge clk); start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Reset in cycle 3 of a conversion: immediate clear, no result.
    @(negedge clk);
    start = 1'b1; ch = 1'b0; adc = 12'hF00;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_busy", busy_o, 1'b0);
    check("abort_angle", angle_o, 16'h0000);
    check("abort_sat", sat_o, 1'b0);
    zero_m[0] = 0; zero_m[1] = 0;
    last_angle = '0;
    @(negedge clk); nrst = 1'b1;
    repeat (12) @(negedge clk);
    // Offsets were cleared by reset.
    convert(1, 12'h800); drain();

    // Offset write during a conversion on the same channel.
    write_zero(0, 200);
    convert(0, 12'h900);
    write_zero(0, -300);
    drain();
    convert(0, 12'h900); drain();

    // Offset write in the same cycle as the start on that channel.
    @(negedge clk);
    start = 1'b1; ch = 1'b1; adc = 12'h700;
    zwr = 1'b1; zch = 1'b1; zval = 12'd50;
    push_exp(1, 12'h700, edge_cnt + 1);
    zero_m[1] = 50;
    @(negedge clk);
    start = 1'b0; zwr = 1'b0;
    drain();
    convert(1, 12'h800); drain();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
